// File: rtl/s2_serial_receiver.sv
// S2 serial receiver: deserializes sen/sd frames (address then data, MSB first) into RB2 writes.
// Optional macro RB2_READBACK_EN adds a read-back verify of every RB2 write.
module s2_serial_receiver #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned NUM_PKT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              done,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned PKT_W   = $clog2(NUM_PKT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [PKT_W-1:0] LAST_PKT = PKT_W'(NUM_PKT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_VERIFY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state, nxt;
  logic [FRAME_W-1:0]  shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic [PKT_W-1:0]    pkt_cnt;
  logic                err_pulse;
  logic                pkt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    err_pulse = 1'b0;
    pkt_inc   = 1'b0;
    case (state)
      S_IDLE: if (!sen) nxt = S_RECV;
      S_RECV: begin
        if (sen) begin
          if (bit_cnt == CNT_FULL) begin
            nxt = S_WRITE;
          end else begin
            nxt       = S_IDLE;
            err_pulse = 1'b1;
          end
        end
      end
`ifdef RB2_READBACK_EN
      S_WRITE:  nxt = S_VERIFY;
      S_VERIFY: nxt = S_CHECK;
      // RB2_Q reflects the address presented during VERIFY
      S_CHECK: begin
        if (RB2_Q == RB2_D) begin
          pkt_inc = 1'b1;
          nxt     = (pkt_cnt == LAST_PKT) ? S_DONE : S_IDLE;
        end else begin
          err_pulse = 1'b1;
          nxt       = S_IDLE;
        end
      end
`else
      S_WRITE: begin
        pkt_inc = 1'b1;
        nxt     = (pkt_cnt == LAST_PKT) ? S_DONE : S_IDLE;
      end
`endif
      S_DONE:  nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

`ifndef RB2_READBACK_EN
  logic unused_q;
  assign unused_q = ^RB2_Q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= '0;
      bit_cnt   <= '0;
      pkt_cnt   <= '0;
      RB2_RW    <= 1'b1;
      RB2_A     <= '0;
      RB2_D     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (state == S_IDLE && !sen) begin
        shift   <= {shift[FRAME_W-2:0], sd};
        bit_cnt <= CNT_W'(1);
      end else if (state == S_RECV && !sen) begin
        shift <= {shift[FRAME_W-2:0], sd};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // Outputs are registered from the next state so the strobe is glitch-free
      RB2_RW <= (nxt != S_WRITE);
      if (state == S_RECV && nxt == S_WRITE) begin
        RB2_A <= shift[FRAME_W-1:DATA_W];
        RB2_D <= shift[DATA_W-1:0];
      end
      if (pkt_inc) pkt_cnt <= pkt_cnt + PKT_W'(1);
      frame_err <= err_pulse;
      done      <= (nxt == S_DONE);
    end
  end

endmodule
